// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM encoding and merge buffer for lsu_rmw.
// Also provides the wrapped word-address helper used for memory decode.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] wdata;
      logic [31:0] word;
   } mbuf_t;

   // Word index wraps modulo the memory size, as the memory decodes it.
   function automatic logic [31:0] word_addr(
      input logic [31:0] a,
      input int unsigned words
   );
      logic [31:0] idx;
      idx = {2'b00, a[31:2]} % words;
      return idx << 2;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte/half lane logic for loads and stores.
// Ports: funct3/off/word/wdata in; ld_data (extended), st_data (merged) out.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      unique case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];

      ld_data = word;
      unique case (1'b1)
         (funct3 == F3_B):  ld_data = {{24{b[7]}}, b};
         (funct3 == F3_H):  ld_data = {{16{h[15]}}, h};
         (funct3 == F3_BU): ld_data = {24'd0, b};
         (funct3 == F3_HU): ld_data = {16'd0, h};
         default:           ld_data = word;
      endcase

      st_data = word;
      unique case (1'b1)
         (funct3 == F3_B): begin
            unique case (off)
               2'd0:    st_data[7:0]   = wdata[7:0];
               2'd1:    st_data[15:8]  = wdata[7:0];
               2'd2:    st_data[23:16] = wdata[7:0];
               default: st_data[31:24] = wdata[7:0];
            endcase
         end
         (funct3 == F3_H): begin
            if (off[1]) st_data[31:16] = wdata[15:0];
            else        st_data[15:0]  = wdata[15:0];
         end
         default: st_data = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: MEM-stage LSU; byte/half stores done as 2-cycle read-modify-write.
// Ports: CLK/RST_N, req_* in, stall/resp_*/misaligned out, mem_* to memory.
// Optional LSU_MISALIGN_TRAP_EN: suppress misaligned H/W accesses and pulse
// misaligned; otherwise addresses are truncated to natural alignment.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS   = 64,
   parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misaligned,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   state_t      state, state_n;
   mbuf_t       mbuf, mbuf_n;
   logic        rv_n, mis_n;
   logic [31:0] rd_n;
   logic        we_c, stall_c;
   logic        is_ld, is_st, mis;
   logic [31:0] a_idle;

   logic [2:0]  l_f3;
   logic [1:0]  l_off;
   logic [31:0] l_word, l_wdata;
   logic [31:0] l_ld, l_st;

   assign a_idle = word_addr(req_addr, MEM_WORDS);

   // One lane unit: fed by the request in IDLE, by the buffer in MERGE.
   assign l_f3    = (state == MERGE) ? mbuf.f3    : req_funct3;
   assign l_off   = (state == MERGE) ? mbuf.off   : req_addr[1:0];
   assign l_word  = (state == MERGE) ? mbuf.word  : mem_rd;
   assign l_wdata = (state == MERGE) ? mbuf.wdata : req_wdata;

   lsu_lane u_lane (
      .funct3  (l_f3),
      .off     (l_off),
      .word    (l_word),
      .wdata   (l_wdata),
      .ld_data (l_ld),
      .st_data (l_st)
   );

   always_comb begin
      is_ld = req_valid && !req_we &&
              (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      is_st = req_valid && req_we &&
              (req_funct3 inside {F3_B, F3_H, F3_W});
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (is_ld || is_st) &&
            ((((req_funct3 == F3_H) || (req_funct3 == F3_HU)) &&
              req_addr[0]) ||
             ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)));
`else
      mis = 1'b0;
`endif
   end

   always_comb begin
      state_n = state;
      mbuf_n  = mbuf;
      rv_n    = 1'b0;
      rd_n    = resp_rdata;
      mis_n   = 1'b0;
      we_c    = 1'b0;
      stall_c = 1'b0;
      mem_a   = a_idle;
      unique case (state)
         IDLE: begin
            if (mis) begin
               mis_n = 1'b1;
               rv_n  = is_ld;
               if (is_ld) rd_n = 32'd0;
            end else if (is_ld) begin
               rv_n = 1'b1;
               rd_n = l_ld;
            end else if (is_st && (req_funct3 == F3_W)) begin
               we_c = 1'b1;
            end else if (is_st) begin
               stall_c = 1'b1;
               mbuf_n  = '{addr:  a_idle,
                           f3:    req_funct3,
                           off:   req_addr[1:0],
                           wdata: req_wdata,
                           word:  mem_rd};
               state_n = MERGE;
            end
         end
         MERGE: begin
            mem_a   = mbuf.addr;
            we_c    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Gated by reset so a pending merge write drops out asynchronously.
   assign mem_we = we_c & RST_N;
   assign stall  = stall_c & RST_N;
   assign mem_wd = l_st;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         mbuf       <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= RESET_RDATA;
         misaligned <= 1'b0;
      end else begin
         state      <= state_n;
         mbuf       <= mbuf_n;
         resp_valid <= rv_n;
         resp_rdata <= rd_n;
         misaligned <= mis_n;
      end
   end

endmodule
